// File: rtl/svf_multi.sv
// Time-multiplexed Chamberlin state-variable filter bank: all channels share
// one signed multiplier, stepping LP -> HP -> BP per iteration per channel.
//
// state | meaning
// IDLE  | waiting for a sample_clk rise
// LP    | lp += f*bp
// HP    | hp  = x - lp - q*bp
// BP    | bp += f*hp
// WB    | write hp/lp/bp/notch of current channel into its shadow slot
// DONE  | publish all shadow slots, pulse out_valid next cycle
module svf_multi #(
    parameter int W          = 16,
    parameter int CHANNELS   = 2,
    parameter int OVERSAMPLE = 1,
    parameter int F_BASE     = 16500,
    parameter int F_MIN      = 64,
    parameter int F_MAX      = 32000,
    parameter int Q_BASE     = 32767,
    parameter int Q_MIN      = 2048,
    parameter int Q_MAX      = 32767
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sample_clk,
    input  logic [CHANNELS*W-1:0] in_flat,
    input  logic [CHANNELS*W-1:0] freq_flat,
    input  logic [CHANNELS*W-1:0] res_flat,
    output logic [CHANNELS*W-1:0] hp_flat,
    output logic [CHANNELS*W-1:0] lp_flat,
    output logic [CHANNELS*W-1:0] bp_flat,
    output logic [CHANNELS*W-1:0] notch_flat,
    output logic                  out_valid,
    output logic                  busy,
    output logic                  overrun
);

    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int IW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int SW = W + 2;
    localparam logic signed [SW-1:0] SAT_MAX = SW'((2 ** (W - 1)) - 1);
    localparam logic signed [SW-1:0] SAT_MIN = SW'(-(2 ** (W - 1)));

    typedef enum logic [2:0] {S_IDLE, S_LP, S_HP, S_BP, S_WB, S_DONE} state_t;

    function automatic logic signed [W-1:0] sat(input logic signed [SW-1:0] v);
        logic signed [W-1:0] r;
        if (v > SAT_MAX)      r = W'(SAT_MAX);
        else if (v < SAT_MIN) r = W'(SAT_MIN);
        else                  r = W'(v);
        return r;
    endfunction

    function automatic logic signed [W-1:0] clamp(input logic signed [SW-1:0] v,
                                                  input int lo, input int hi);
        logic signed [W-1:0] r;
        if (v < SW'(lo))      r = W'(lo);
        else if (v > SW'(hi)) r = W'(hi);
        else                  r = W'(v);
        return r;
    endfunction

    state_t state, state_n;
    logic [CW-1:0] ch;
    logic [IW-1:0] iter;
    logic sclk_q, rise;

    logic signed [W-1:0] x_s   [CHANNELS];
    logic signed [W-1:0] f_s   [CHANNELS];
    logic signed [W-1:0] q_s   [CHANNELS];
    logic signed [W-1:0] lp_st [CHANNELS];
    logic signed [W-1:0] bp_st [CHANNELS];
    logic signed [W-1:0] sh_hp [CHANNELS];
    logic signed [W-1:0] sh_lp [CHANNELS];
    logic signed [W-1:0] sh_bp [CHANNELS];
    logic signed [W-1:0] sh_nt [CHANNELS];
    logic signed [W-1:0] hp_r;

    logic signed [W-1:0]   mul_a, mul_b;
    logic signed [2*W-1:0] prod;
    logic signed [SW-1:0]  prod_s;

    assign rise   = sample_clk & ~sclk_q;
    assign busy   = (state != S_IDLE);
    assign prod   = (2*W)'(mul_a) * (2*W)'(mul_b);
    assign prod_s = SW'(prod >>> (W - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    // Next-state decode and shared multiplier operand select
    always_comb begin
        state_n = state;
        mul_a   = f_s[ch];
        mul_b   = bp_st[ch];
        case (state)
            S_IDLE: if (rise) state_n = S_LP;
            S_LP:   state_n = S_HP;
            S_HP: begin
                mul_a   = q_s[ch];
                state_n = S_BP;
            end
            S_BP: begin
                mul_b   = hp_r;
                state_n = (iter == IW'(OVERSAMPLE - 1)) ? S_WB : S_LP;
            end
            S_WB:   state_n = (ch == CW'(CHANNELS - 1)) ? S_DONE : S_LP;
            S_DONE: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Edge detect, overrun flag, snapshot, filter datapath and output publish
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_q     <= 1'b0;
            overrun    <= 1'b0;
            out_valid  <= 1'b0;
            ch         <= '0;
            iter       <= '0;
            hp_r       <= '0;
            hp_flat    <= '0;
            lp_flat    <= '0;
            bp_flat    <= '0;
            notch_flat <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                x_s[c]   <= '0;
                f_s[c]   <= '0;
                q_s[c]   <= '0;
                lp_st[c] <= '0;
                bp_st[c] <= '0;
                sh_hp[c] <= '0;
                sh_lp[c] <= '0;
                sh_bp[c] <= '0;
                sh_nt[c] <= '0;
            end
        end else begin
            sclk_q    <= sample_clk;
            out_valid <= 1'b0;
            if (rise && busy) overrun <= 1'b1;
            case (state)
                S_IDLE: if (rise) begin
                    ch   <= '0;
                    iter <= '0;
                    for (int c = 0; c < CHANNELS; c++) begin
                        x_s[c] <= in_flat[c*W +: W];
                        f_s[c] <= clamp(SW'(F_BASE) + SW'($signed(freq_flat[c*W +: W]) >>> 1),
                                        F_MIN, F_MAX);
                        q_s[c] <= clamp(SW'(Q_BASE) - SW'($signed(res_flat[c*W +: W]) >>> 1),
                                        Q_MIN, Q_MAX);
                    end
                end
                S_LP: lp_st[ch] <= sat(SW'(lp_st[ch]) + prod_s);
                S_HP: hp_r <= sat(SW'(x_s[ch]) - SW'(lp_st[ch]) - prod_s);
                S_BP: begin
                    bp_st[ch] <= sat(SW'(bp_st[ch]) + prod_s);
                    if (iter == IW'(OVERSAMPLE - 1)) iter <= '0;
                    else                             iter <= iter + 1'b1;
                end
                S_WB: begin
                    sh_hp[ch] <= hp_r;
                    sh_lp[ch] <= lp_st[ch];
                    sh_bp[ch] <= bp_st[ch];
                    sh_nt[ch] <= sat(SW'(hp_r) + SW'(lp_st[ch]));
                    if (ch == CW'(CHANNELS - 1)) ch <= '0;
                    else                         ch <= ch + 1'b1;
                end
                S_DONE: begin
                    out_valid <= 1'b1;
                    for (int c = 0; c < CHANNELS; c++) begin
                        hp_flat[c*W +: W]    <= sh_hp[c];
                        lp_flat[c*W +: W]    <= sh_lp[c];
                        bp_flat[c*W +: W]    <= sh_bp[c];
                        notch_flat[c*W +: W] <= sh_nt[c];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
